turfio_spi_target: RTL and testbench

- SPI target (responder) that lets an external SPI master (mode 0, MSB first) read and write the TURFIO internal register space.
- Oversamples SCLK/CS_B/MOSI in the wishbone clock domain and decodes frames into single 32-bit accesses on a wishbone initiator port.
- It is the far end of the shift-register SPI master already used for flash, LMK and JTAG access, so a second board can drive TURFIO registers the same way.

---
 rtl/turfio_spi_target.sv | 210 +++++++++++++++++++++
 tb/tb_turfio_spi_target.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/turfio_spi_target.sv
// SPI target (mode 0, MSB first) bridging an external SPI master onto a 32-bit wishbone initiator.
// Build option: define TURFIO_SPI_TARGET_AUTOINC_EN for address-incrementing burst frames.
module turfio_spi_target #(
  parameter int          TIMEOUT      = 255,
  parameter logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF,
  parameter int          DUMMY_BITS   = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        SCLK,
  input  logic        CS_B,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_T,
  output logic        m_wb_cyc_o,
  output logic        m_wb_stb_o,
  output logic        m_wb_we_o,
  output logic [11:0] m_wb_adr_o,
  output logic [31:0] m_wb_dat_o,
  output logic [3:0]  m_wb_sel_o,
  input  logic [31:0] m_wb_dat_i,
  input  logic        m_wb_ack_i,
  input  logic        m_wb_err_i,
  output logic        xfer_done_o,
  output logic        xfer_err_o
);

`ifdef TURFIO_SPI_TARGET_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_HEADER, ST_DUMMY, ST_DATA_IN, ST_WB_WR, ST_DATA_OUT, ST_DONE
  } state_t;

  state_t state, state_nxt;

  logic sclk_s1, sclk_s2, sclk_h, cs_s1, cs_s2, mosi_s1, mosi_s2;
  logic rise, fall, cs_act;
  logic [5:0]    bit_cnt;
  logic [30:0]   shift_in;
  logic [31:0]   shift_out, data_word, rd_data, req_dat;
  logic [11:0]   cur_adr, req_adr, hdr_adr;
  logic          req_pend, req_we, keep, rd_done, word_done;
  logic [TW-1:0] tmo_cnt;
  logic          hdr_end, dummy_end, in_end, out_end, tmo_hit, wb_term, own, abort;

  // NOTE: SPI inputs are asynchronous; two flops each bound metastability before any logic sees them.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      {sclk_s1, sclk_s2, sclk_h} <= 3'b000;
      {cs_s1, cs_s2}             <= 2'b11;
      {mosi_s1, mosi_s2}         <= 2'b00;
    end else begin
      {sclk_s1, sclk_s2, sclk_h} <= {SCLK, sclk_s1, sclk_s2};
      {cs_s1, cs_s2}             <= {CS_B, cs_s1};
      {mosi_s1, mosi_s2}         <= {MOSI, mosi_s1};
    end
  end

  assign rise      = sclk_s2 & ~sclk_h;
  assign fall      = ~sclk_s2 & sclk_h;
  assign cs_act    = ~cs_s2;
  assign data_word = {shift_in, mosi_s2};
  assign hdr_adr   = {shift_in[10:1], 2'b00};

  assign hdr_end   = (state == ST_HEADER)   && rise && (bit_cnt == 6'd15);
  assign dummy_end = (state == ST_DUMMY)    && rise && (bit_cnt == 6'(DUMMY_BITS - 1));
  assign in_end    = (state == ST_DATA_IN)  && rise && (bit_cnt == 6'd31);
  assign out_end   = (state == ST_DATA_OUT) && rise && (bit_cnt == 6'd31);

  assign tmo_hit = ~m_wb_ack_i & ~m_wb_err_i & (tmo_cnt == TW'(TIMEOUT - 1));
  assign wb_term = m_wb_cyc_o & (m_wb_ack_i | m_wb_err_i | tmo_hit);
  // A bus result only counts while the frame that issued it is still selected.
  assign own     = keep & cs_act;
  assign abort   = ~cs_act && ((state == ST_HEADER) || (state == ST_DUMMY) ||
                   (((state == ST_DATA_IN) || (state == ST_DATA_OUT)) &&
                    ((bit_cnt != 6'd0) || !word_done)));

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // NOTE: state_nxt gets its default first so no path through the case leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (cs_act) state_nxt = ST_HEADER;
      ST_HEADER:   if (hdr_end) state_nxt = shift_in[14] ? ST_DATA_IN : ST_DUMMY;
      ST_DUMMY:    if (dummy_end) state_nxt = ST_DATA_OUT;
      ST_DATA_IN:  if (in_end && !AUTOINC) state_nxt = ST_WB_WR;
      ST_WB_WR:    if (wb_term && keep) state_nxt = ST_DONE;
      ST_DATA_OUT: if (out_end && !AUTOINC) state_nxt = ST_DONE;
      ST_DONE:     state_nxt = ST_DONE;
      default:     state_nxt = ST_IDLE;
    endcase
    if (!cs_act) state_nxt = ST_IDLE;
  end

  assign MISO       = (state == ST_DATA_OUT) & shift_out[31];
  assign MISO_T     = (state == ST_IDLE);
  assign m_wb_sel_o = 4'hF;

  // NOTE: sequential state uses non-blocking assignments; later statements in this block override earlier ones.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      m_wb_cyc_o <= 1'b0;  m_wb_stb_o <= 1'b0;  m_wb_we_o <= 1'b0;
      m_wb_adr_o <= '0;    m_wb_dat_o <= '0;    tmo_cnt   <= '0;
      xfer_done_o <= 1'b0; xfer_err_o <= 1'b0;
      bit_cnt <= '0;  shift_in <= '0;  shift_out <= '0;  rd_data <= '0;
      cur_adr <= '0;  req_adr <= '0;   req_dat <= '0;    req_we <= 1'b0;
      req_pend <= 1'b0; keep <= 1'b0; rd_done <= 1'b0; word_done <= 1'b0;
    end else begin
      xfer_done_o <= 1'b0;
      xfer_err_o  <= 1'b0;

      // Wishbone engine: one access at a time, launched from the request registers.
      if (m_wb_cyc_o) begin
        if (wb_term) begin
          m_wb_cyc_o <= 1'b0;
          m_wb_stb_o <= 1'b0;
          keep       <= 1'b0;
          if (own) begin
            xfer_done_o <= m_wb_ack_i & ~m_wb_err_i;
            xfer_err_o  <= ~(m_wb_ack_i & ~m_wb_err_i);
            if (!m_wb_we_o) begin
              rd_data <= (m_wb_ack_i & ~m_wb_err_i) ? m_wb_dat_i : TIMEOUT_DATA;
              rd_done <= 1'b1;
            end
          end
        end else begin
          tmo_cnt <= tmo_cnt + TW'(1);
        end
      end else if (req_pend) begin
        m_wb_cyc_o <= 1'b1;
        m_wb_stb_o <= 1'b1;
        m_wb_we_o  <= req_we;
        m_wb_adr_o <= req_adr;
        m_wb_dat_o <= req_dat;
        tmo_cnt    <= '0;
        keep       <= 1'b1;
        req_pend   <= 1'b0;
      end

      if (rise && ((state == ST_HEADER) || (state == ST_DATA_IN)))
        shift_in <= data_word[30:0];

      if (state_nxt != state || in_end || out_end)
        bit_cnt <= '0;
      else if (rise && ((state == ST_HEADER) || (state == ST_DUMMY) ||
                        (state == ST_DATA_IN) || (state == ST_DATA_OUT)))
        bit_cnt <= bit_cnt + 6'd1;

      if (state == ST_IDLE && cs_act) begin
        word_done <= 1'b0;
        rd_done   <= 1'b0;
      end

      if (hdr_end) begin
        cur_adr <= hdr_adr;
        if (!shift_in[14]) begin
          req_pend <= 1'b1;
          req_we   <= 1'b0;
          req_adr  <= hdr_adr;
        end
      end

      if (in_end) begin
        req_pend  <= 1'b1;
        req_we    <= 1'b1;
        req_adr   <= cur_adr;
        req_dat   <= data_word;
        cur_adr   <= cur_adr + 12'd4;
        word_done <= 1'b1;
      end

      // Word load: a read not yet returned is reported late and its eventual result discarded.
      if (dummy_end || (out_end && AUTOINC)) begin
        shift_out <= rd_done ? rd_data : TIMEOUT_DATA;
        rd_done   <= 1'b0;
        if (!rd_done) begin
          xfer_err_o  <= 1'b1;
          xfer_done_o <= 1'b0;
          keep        <= 1'b0;
        end
        if (AUTOINC) begin
          req_pend <= 1'b1;
          req_we   <= 1'b0;
          req_adr  <= cur_adr + 12'd4;
          cur_adr  <= cur_adr + 12'd4;
        end
      end else if (fall && (state == ST_DATA_OUT) && (bit_cnt != 6'd0)) begin
        shift_out <= {shift_out[30:0], 1'b0};
      end

      if (out_end) word_done <= 1'b1;

      if (state != ST_IDLE && !cs_act) begin
        req_pend <= 1'b0;
        keep     <= 1'b0;
        if (abort) xfer_err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_turfio_spi_target.sv
// Scoreboard bench for turfio_spi_target: SPI master model, wishbone responder/monitor, pulse counters.
module tb_turfio_spi_target;
  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        SCLK = 1'b0, CS_B = 1'b1, MOSI = 1'b0;
  logic        MISO, MISO_T;
  logic        m_wb_cyc_o, m_wb_stb_o, m_wb_we_o;
  logic [11:0] m_wb_adr_o;
  logic [31:0] m_wb_dat_o;
  logic [3:0]  m_wb_sel_o;
  logic [31:0] m_wb_dat_i = '0;
  logic        m_wb_ack_i = 1'b0, m_wb_err_i = 1'b0;
  logic        xfer_done_o, xfer_err_o;

  always #5 wb_clk_i = ~wb_clk_i;

  turfio_spi_target dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .SCLK(SCLK), .CS_B(CS_B), .MOSI(MOSI), .MISO(MISO), .MISO_T(MISO_T),
    .m_wb_cyc_o(m_wb_cyc_o), .m_wb_stb_o(m_wb_stb_o), .m_wb_we_o(m_wb_we_o),
    .m_wb_adr_o(m_wb_adr_o), .m_wb_dat_o(m_wb_dat_o), .m_wb_sel_o(m_wb_sel_o),
    .m_wb_dat_i(m_wb_dat_i), .m_wb_ack_i(m_wb_ack_i), .m_wb_err_i(m_wb_err_i),
    .xfer_done_o(xfer_done_o), .xfer_err_o(xfer_err_o)
  );

  typedef struct {
    logic        we;
    logic [11:0] adr;
    logic [31:0] dat;
  } wb_exp_t;

  wb_exp_t     wb_q[$];
  logic [31:0] rd_q[$];

  int n_checks = 0, n_err = 0;
  int ack_lat = 3;
  int n_cyc = 0, n_done = 0, n_errp = 0, last_cyc_len = 0;
  logic [31:0] rd_value = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Wishbone responder and monitor: acks after ack_lat cycles (never if negative).
  initial begin
    bit in_cyc = 1'b0;
    int len = 0;
    wb_exp_t e;
    forever begin
      @(negedge wb_clk_i);
      m_wb_ack_i = 1'b0;
      m_wb_dat_i = rd_value;
      if (m_wb_cyc_o) begin
        if (!in_cyc) begin
          in_cyc = 1'b1;
          len = 0;
          if (wb_q.size() == 0) begin
            check("wb_unexpected_cyc", 32'd1, 32'd0);
          end else begin
            e = wb_q.pop_front();
            check("wb_we", 32'(m_wb_we_o), 32'(e.we));
            check("wb_adr", 32'(m_wb_adr_o), 32'(e.adr));
            check("wb_sel", 32'(m_wb_sel_o), 32'hF);
            check("wb_stb", 32'(m_wb_stb_o), 32'd1);
            if (e.we) check("wb_dat", m_wb_dat_o, e.dat);
          end
        end
        len++;
        if (ack_lat >= 0 && len == ack_lat) m_wb_ack_i = 1'b1;
      end else if (in_cyc) begin
        in_cyc = 1'b0;
        last_cyc_len = len;
        n_cyc++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge wb_clk_i);
      if (xfer_done_o) n_done++;
      if (xfer_err_o)  n_errp++;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // SPI master, mode 0: SCLK = wb_clk/8, MOSI set while SCLK low, MISO sampled at the rise.
  task automatic spi_bit(input logic b, output logic r);
    MOSI = b;
    repeat (4) @(negedge wb_clk_i);
    r = MISO;
    SCLK = 1'b1;
    repeat (4) @(negedge wb_clk_i);
    SCLK = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    logic r;
    for (int i = n - 1; i >= 0; i--) spi_bit(v[i], r);
  endtask

  task automatic recv_word(output logic [31:0] w);
    logic r;
    for (int i = 31; i >= 0; i--) begin
      spi_bit(1'b0, r);
      w[i] = r;
    end
  endtask

  task automatic cs_begin();
    @(negedge wb_clk_i);
    CS_B = 1'b0;
    repeat (4) @(negedge wb_clk_i);
  endtask

  task automatic cs_end();
    repeat (4) @(negedge wb_clk_i);
    CS_B = 1'b1;
    repeat (8) @(negedge wb_clk_i);
  endtask

  task automatic write_frame(input logic [15:0] hdr, input logic [31:0] dat);
    cs_begin();
    send_bits(32'(hdr), 16);
    send_bits(dat, 32);
    cs_end();
  endtask

  task automatic read_frame(input logic [15:0] hdr, output logic [31:0] dat);
    cs_begin();
    send_bits(32'(hdr), 16);
    send_bits(32'd0, 8);
    recv_word(dat);
    check("miso_t_in_frame", 32'(MISO_T), 32'd0);
    cs_end();
  endtask

  initial begin
    int d0, e0, c0;
    logic [31:0] got;
    logic [31:0] burst [3];
    burst[0] = 32'h11111111;
    burst[1] = 32'h22222222;
    burst[2] = 32'h33333333;

    repeat (4) @(negedge wb_clk_i);
    check("rst_miso_t", 32'(MISO_T), 32'd1);
    check("rst_miso", 32'(MISO), 32'd0);
    check("rst_cyc", 32'(m_wb_cyc_o), 32'd0);
    check("rst_stb", 32'(m_wb_stb_o), 32'd0);
    check("rst_we", 32'(m_wb_we_o), 32'd0);
    check("rst_adr", 32'(m_wb_adr_o), 32'd0);
    check("rst_sel", 32'(m_wb_sel_o), 32'hF);
    check("rst_done", 32'(xfer_done_o), 32'd0);
    check("rst_err", 32'(xfer_err_o), 32'd0);
    wb_rst_i = 1'b0;
    repeat (4) @(negedge wb_clk_i);

    // Single write, acked after 3 cycles.
    d0 = n_done; e0 = n_errp; c0 = n_cyc;
    ack_lat = 3;
    wb_q.push_back('{1'b1, 12'h120, 32'hCAFEF00D});
    write_frame(16'h8123, 32'hCAFEF00D);
    check("wr_cyc_count", 32'(n_cyc - c0), 32'd1);
    check("wr_done", 32'(n_done - d0), 32'd1);
    check("wr_err", 32'(n_errp - e0), 32'd0);
    check("wr_miso_t_idle", 32'(MISO_T), 32'd1);

`ifndef TURFIO_SPI_TARGET_AUTOINC_EN
    // Single read, acked after 2 cycles.
    d0 = n_done; e0 = n_errp;
    ack_lat = 2; rd_value = 32'h12345678;
    wb_q.push_back('{1'b0, 12'h044, 32'h0});
    rd_q.push_back(32'h12345678);
    read_frame(16'h0044, got);
    check("rd_data", got, rd_q.pop_front());
    check("rd_done", 32'(n_done - d0), 32'd1);
    check("rd_err", 32'(n_errp - e0), 32'd0);
    check("rd_miso_t_idle", 32'(MISO_T), 32'd1);

    // Read with no ack: timeout after 255 cycles, filler data, one error pulse.
    d0 = n_done; e0 = n_errp;
    ack_lat = -1;
    wb_q.push_back('{1'b0, 12'h088, 32'h0});
    rd_q.push_back(32'hDEADBEEF);
    read_frame(16'h008B, got);
    check("tmo_data", got, rd_q.pop_front());
    check("tmo_cyc_len", 32'(last_cyc_len), 32'd255);
    check("tmo_err", 32'(n_errp - e0), 32'd1);
    check("tmo_done", 32'(n_done - d0), 32'd0);
`endif

    // Abort after 20 write data bits, then a full frame.
    e0 = n_errp; c0 = n_cyc;
    ack_lat = 1;
    cs_begin();
    send_bits(32'h8200, 16);
    send_bits(32'hABCDE, 20);
    cs_end();
    check("abort_cyc_count", 32'(n_cyc - c0), 32'd0);
    check("abort_err", 32'(n_errp - e0), 32'd1);
    check("abort_idle", 32'(MISO_T), 32'd1);
    d0 = n_done;
    wb_q.push_back('{1'b1, 12'h204, 32'hA5A55A5A});
    write_frame(16'h8206, 32'hA5A55A5A);
    check("after_abort_done", 32'(n_done - d0), 32'd1);

`ifndef TURFIO_SPI_TARGET_AUTOINC_EN
    // Reset during DATA_OUT while a read is still outstanding.
    ack_lat = -1;
    wb_q.push_back('{1'b0, 12'h010, 32'h0});
    cs_begin();
    send_bits(32'h0010, 16);
    send_bits(32'd0, 8);
    send_bits(32'd0, 5);
    check("pre_rst_cyc", 32'(m_wb_cyc_o), 32'd1);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    CS_B = 1'b1;
    @(negedge wb_clk_i);
    check("midrst_miso_t", 32'(MISO_T), 32'd1);
    check("midrst_cyc", 32'(m_wb_cyc_o), 32'd0);
    repeat (4) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    repeat (8) @(negedge wb_clk_i);
    ack_lat = 2; rd_value = 32'h13579BDF;
    wb_q.push_back('{1'b0, 12'h020, 32'h0});
    rd_q.push_back(32'h13579BDF);
    read_frame(16'h0020, got);
    check("post_rst_rd_data", got, rd_q.pop_front());
`endif

    // Three-word write frame at the top of the address space.
    d0 = n_done; e0 = n_errp;
    ack_lat = 2;
    wb_q.push_back('{1'b1, 12'hFFC, burst[0]});
`ifdef TURFIO_SPI_TARGET_AUTOINC_EN
    wb_q.push_back('{1'b1, 12'h000, burst[1]});
    wb_q.push_back('{1'b1, 12'h004, burst[2]});
`endif
    cs_begin();
    send_bits(32'h8FFC, 16);
    for (int i = 0; i < 3; i++) send_bits(burst[i], 32);
    cs_end();
`ifdef TURFIO_SPI_TARGET_AUTOINC_EN
    check("burst_done", 32'(n_done - d0), 32'd3);
`else
    check("burst_done", 32'(n_done - d0), 32'd1);
`endif
    check("burst_err", 32'(n_errp - e0), 32'd0);

    repeat (20) @(negedge wb_clk_i);
    check("wb_q_drained", 32'(wb_q.size()), 32'd0);
    check("final_cyc_idle", 32'(m_wb_cyc_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
